// File: rtl/mod_residue_folder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_residue_folder_if
//  Brief    : Operand-in / residue-out handshake bundle for mod_residue_folder.
//  Revision : 1.0 - initial release
// ============================================================================
interface mod_residue_folder_if #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH*CHUNKS-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/mod_residue_folder.sv
`default_nettype none
// ============================================================================
//  Module   : mod_residue_folder
//  Brief    : Folds a CHUNKS*WIDTH operand, one chunk per cycle, into a residue
//             modulo 2^WIDTH-1 using end-around-carry addition.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_residue_folder #(
    parameter int WIDTH     = 8,
    parameter int CHUNKS    = 8,
    parameter int NORMALIZE = 1
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    mod_residue_folder_if.slave  bus,
    output logic                 busy
);

    localparam int c_OP_W  = WIDTH * CHUNKS;
    localparam int c_CNT_W = $clog2(CHUNKS + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CHUNKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_FOLD = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [c_OP_W-1:0]   r_shift;
    logic [WIDTH-1:0]    r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_busy;

    logic [WIDTH-1:0]    w_chunk;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_acc_next;
    logic [WIDTH-1:0]    w_residue;

    assign w_chunk = r_shift[WIDTH-1:0];
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_chunk};

    // Adding the carry back cannot overflow: the low WIDTH bits are at most
    // 2^WIDTH-2 whenever the carry is set.
    assign w_acc_next = w_sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
    assign w_residue  = ((NORMALIZE != 0) && (w_acc_next == {WIDTH{1'b1}}))
                        ? {WIDTH{1'b0}} : w_acc_next;

    // in_ready is a register so it stays low throughout reset and only rises
    // on the first edge after release (and the edge after a DONE handshake).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_shift     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_shift    <= bus.in_data;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= c_S_FOLD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                c_S_FOLD: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift >> WIDTH;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= c_S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_residue;
                    end
                end
                c_S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= c_S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: doc/mod_residue_folder.md
# mod_residue_folder

Sequential residue generator feeding the end-around-carry (mod 2^WIDTH−1) adder stage. It accepts one wide operand of CHUNKS×WIDTH bits and folds it, one WIDTH-bit chunk per cycle, into a WIDTH-bit residue modulo 2^WIDTH−1. The residue is presented on a valid/ready output for the downstream modular adders. Folding reuses the end-around-carry rule: low bits of the sum plus the carry-out.

## Interface
- WIDTH, 8: residue / chunk width in bits.
- CHUNKS, 8: number of chunks per operand. The operand is WIDTH×CHUNKS bits wide. Legal range is 2..64.
- NORMALIZE, 1: 1 maps an all-ones result to zero. 0 passes it through unchanged.

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH*CHUNKS  operand. Chunk 0 is bits [WIDTH−1:0].
- out_valid  output  1  residue available.
- out_ready  input  1  downstream accepts residue.
- out_data  output  WIDTH  residue.
- busy  output  1  high in FOLD and DONE.

## Operation
- FSM states and transitions:
  - IDLE → FOLD on in_valid && in_ready.
  - FOLD → DONE after CHUNKS fold cycles.
  - DONE → IDLE on out_valid && out_ready.
- Acceptance edge: the operand is loaded into a shift register, the accumulator is cleared to 0, and the chunk counter is cleared to 0.
- Each FOLD edge:
  - s = acc + chunk, computed as a (WIDTH+1)-bit sum.
  - acc ← s[WIDTH−1:0] + s[WIDTH].
  - The shift register moves right by WIDTH. The counter increments.
- The second end-around addition never produces a carry, because acc ≤ 2^WIDTH−1. The accumulator stays WIDTH bits.
- Entering DONE: out_data ← (NORMALIZE && acc == all-ones) ? 0 : acc.
- Result semantics:
  - A zero operand gives 0.
  - A nonzero multiple of 2^WIDTH−1 gives all-ones when NORMALIZE=0, and 0 when NORMALIZE=1.
  - Any other operand gives operand mod (2^WIDTH−1).
- in_ready = (state == IDLE). Inputs are ignored outside IDLE.
- There is no accept in the same cycle as the output handshake. in_ready rises on the cycle after the DONE handshake.
- out_data and out_valid are registered. out_data is held stable while out_valid && !out_ready.
- The counter is ceil(log2(CHUNKS+1)) bits. It never wraps within an operation, and it is reset on every acceptance.

## Timing
- Reset, asynchronous on rst_n low:
  - state = IDLE, acc = 0, shift register = 0, counter = 0.
  - out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 0 while rst_n is low, and 1 from the first cycle after release.
- Reset mid-operation aborts the fold with no output produced. The next accepted operand gives the correct result.
- Latency: an operand accepted at edge E0 is folded on edges E1..E_CHUNKS. out_valid is high after edge E_CHUNKS, so latency is CHUNKS cycles.
- Throughput: one operand per CHUNKS+2 cycles when out_ready is held high.
- busy is high from the edge after acceptance through the output handshake edge.
- in_valid may drop or change while not ready, with no effect on the block.
- out_valid may not drop without a handshake.

## Test plan
- Ordinary operand: in_data = 0x0102030405060708 (WIDTH=8, CHUNKS=8) → out_data = 0x24, with out_valid exactly 8 cycles after acceptance.
- Carry chain: in_data = 0x8080808080808080 → out_data = 0x04. Intermediate acc values are 01, 81, 02, 82, 03, 83, 04 after the second through eighth fold edges.
- All-ones operand:
  - in_data = 0xFFFFFFFFFFFFFFFF with NORMALIZE=1 → 0x00.
  - Same operand with NORMALIZE=0 → 0xFF.
  - in_data = 0 with NORMALIZE=0 → 0x00.
- Backpressure: hold out_ready low for 5 cycles after out_valid, with in_valid held high and in_data changing.
  - out_data stays constant and in_ready stays 0 throughout.
  - The held operand is accepted only on the cycle after the handshake.
- Reset mid-fold: assert rst_n low after fold edge 3 → out_valid = 0 and busy = 0 immediately.
  - After release, in_data = 0x0102030405060708 still gives 0x24.
- Random regression: 10k random operands with random out_ready stalls, checked against the model operand mod 255, including the 0/0xFF rule for each NORMALIZE setting. Repeat with WIDTH=16, CHUNKS=4.
